// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder behind the SPI slave shifter: the first byte of a
// frame is R/nW + start address, later bytes are write data or read slots.
module spi_reg_bridge #(
    parameter bit         AUTO_INC = 1'b1,
    parameter logic [7:0] FILL     = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic       byte_valid,
    input  logic [0:7] byte_data,
    output logic [0:7] tx_data,
    output logic [0:6] reg_addr,
    output logic [0:7] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [0:7] reg_rdata,
    output logic [7:0] nbytes,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    localparam logic [0:6] ADDR_STEP = AUTO_INC ? 7'd1 : 7'd0;

    state_t     state;
    state_t     state_next;
    logic [1:0] gap;
    logic       rd_pending;
    logic       live;
    logic       byte_ok;
    logic       byte_late;
    logic       frame_start;
    logic       cmd_ok;
    logic       wr_ok;
    logic       rd_ok;
    logic       read_issue;

    // NOTE: state uses <= so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no latch is inferred on unlisted paths.
    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (frame) state_next = CMD;
        end else if (!frame) begin
            state_next = IDLE;
        end else if (state == CMD && byte_ok) begin
            state_next = byte_data[0] ? RD : WR;
        end
    end

    always_comb begin
        live        = frame && (state != IDLE);
        byte_ok     = byte_valid && live && (gap == 2'd0);
        byte_late   = byte_valid && live && (gap != 2'd0);
        frame_start = (state == IDLE) && frame;
        cmd_ok      = byte_ok && (state == CMD);
        wr_ok       = byte_ok && (state == WR);
        rd_ok       = byte_ok && (state == RD);
        read_issue  = (cmd_ok && byte_data[0]) || rd_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data    <= FILL;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            nbytes     <= '0;
            overrun    <= 1'b0;
            gap        <= '0;
            rd_pending <= 1'b0;
        end else begin
            reg_we     <= wr_ok;
            reg_re     <= read_issue;
            rd_pending <= reg_re;

            if (wr_ok) reg_wdata <= byte_data;

            // Writes advance after their strobe; reads advance before theirs.
            if (cmd_ok)                reg_addr <= byte_data[1:7];
            else if (rd_ok || reg_we)  reg_addr <= reg_addr + ADDR_STEP;

            // gap counts down the two cycles after an accepted byte.
            if (state == IDLE)     gap <= '0;
            else if (byte_ok)      gap <= 2'd2;
            else if (gap != 2'd0)  gap <= gap - 2'd1;

            if (frame_start)                      nbytes <= '0;
            else if (byte_ok && nbytes != 8'hFF)  nbytes <= nbytes + 8'd1;

            if (frame_start)     overrun <= 1'b0;
            else if (byte_late)  overrun <= 1'b1;

            // A read that returns after the frame is gone must not leak out.
            if (frame_start)      tx_data <= FILL;
            else if (rd_pending)  tx_data <= (state == IDLE || !frame) ? FILL : reg_rdata;
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected bus cycles are queued as bytes
// are driven and popped when the strobes appear.
module tb_spi_reg_bridge;
    logic       clk = 1'b0;
    logic       reset;
    logic       frame;
    logic       byte_valid;
    logic [0:7] byte_data;

    logic [0:7] tx0, wdata0, rdata0 = '0;
    logic [0:6] addr0;
    logic       we0, re0, ovr0;
    logic [7:0] nbytes0;

    logic [0:7] tx1, wdata1, rdata1 = '0;
    logic [0:6] addr1;
    logic       we1, re1, ovr1;
    logic [7:0] nbytes1;

    typedef struct {
        bit         wr;
        logic [6:0] addr;
        logic [7:0] data;
    } bus_op_t;

    bus_op_t q0[$];
    bus_op_t q1[$];
    bit      chk1 = 1'b0;
    int      checks = 0;
    int      errors = 0;

    spi_reg_bridge #(.AUTO_INC(1'b1), .FILL(8'hFF)) dut0 (
        .clk(clk), .reset(reset), .frame(frame), .byte_valid(byte_valid),
        .byte_data(byte_data), .tx_data(tx0), .reg_addr(addr0), .reg_wdata(wdata0),
        .reg_we(we0), .reg_re(re0), .reg_rdata(rdata0), .nbytes(nbytes0), .overrun(ovr0)
    );

    spi_reg_bridge #(.AUTO_INC(1'b0), .FILL(8'hFF)) dut1 (
        .clk(clk), .reset(reset), .frame(frame), .byte_valid(byte_valid),
        .byte_data(byte_data), .tx_data(tx1), .reg_addr(addr1), .reg_wdata(wdata1),
        .reg_we(we1), .reg_re(re1), .reg_rdata(rdata1), .nbytes(nbytes1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    // Register file model: rdata = addr ^ 5A, valid the cycle after reg_re.
    always @(posedge clk) begin
        if (re0) rdata0 <= {1'b0, addr0} ^ 8'h5A;
        if (re1) rdata1 <= {1'b0, addr1} ^ 8'h5A;
    end

    always @(negedge clk) begin
        bus_op_t e;
        if (we0 || re0) begin
            checks++;
            if (we0 && re0) begin
                errors++;
                $display("FAIL dut0_strobe_excl got we=%b re=%b expected one strobe", we0, re0);
            end else if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected got we=%b re=%b addr=%0d expected no strobe", we0, re0, addr0);
            end else begin
                e = q0.pop_front();
                if (e.wr !== we0 || e.addr !== addr0 || (e.wr && e.data !== wdata0)) begin
                    errors++;
                    $display("FAIL dut0_bus got we=%b addr=%0d wdata=%h expected we=%b addr=%0d wdata=%h",
                             we0, addr0, wdata0, e.wr, e.addr, e.data);
                end
            end
        end
        if (chk1 && (we1 || re1)) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected got we=%b re=%b addr=%0d expected no strobe", we1, re1, addr1);
            end else begin
                e = q1.pop_front();
                if (e.wr !== we1 || e.addr !== addr1) begin
                    errors++;
                    $display("FAIL dut1_bus got we=%b addr=%0d expected we=%b addr=%0d",
                             we1, addr1, e.wr, e.addr);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick(1);
        byte_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame = 1'b1;
        tick(1);
    endtask

    task automatic end_frame();
        frame = 1'b0;
        tick(2);
    endtask

    task automatic push0(input bit wr, input logic [6:0] a, input logic [7:0] d);
        bus_op_t e;
        e.wr = wr; e.addr = a; e.data = d;
        q0.push_back(e);
    endtask

    task automatic push1(input bit wr, input logic [6:0] a, input logic [7:0] d);
        bus_op_t e;
        e.wr = wr; e.addr = a; e.data = d;
        q1.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; frame = 1'b0; byte_valid = 1'b0; byte_data = '0;
        tick(2);
        checks++;
        if ({tx0, addr0, wdata0, we0, re0, nbytes0, ovr0} !== {8'hFF, 7'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut0 got tx=%h addr=%0d wdata=%h we=%b re=%b nbytes=%0d ovr=%b expected FF/0/00/0/0/0/0",
                     tx0, addr0, wdata0, we0, re0, nbytes0, ovr0);
        end
        checks++;
        if (tx1 !== 8'hFF || nbytes1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_dut1 got tx=%h nbytes=%0d expected FF/0", tx1, nbytes1);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_write_burst();
        start_frame();
        send_byte(8'h05); tick(2);
        push0(1'b1, 7'd5, 8'hA1); send_byte(8'hA1); tick(2);
        push0(1'b1, 7'd6, 8'hB2); send_byte(8'hB2); tick(2);
        checks++;
        if (nbytes0 !== 8'd3) begin errors++; $display("FAIL wr_nbytes got %0d expected 3", nbytes0); end
        checks++;
        if (tx0 !== 8'hFF) begin errors++; $display("FAIL wr_tx got %h expected FF", tx0); end
        checks++;
        if (addr0 !== 7'd7) begin errors++; $display("FAIL wr_addr_inc got %0d expected 7", addr0); end
        end_frame();
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL wr_drain got %0d pending expected 0", q0.size()); end
    endtask

    task automatic test_read_burst();
        start_frame();
        push0(1'b0, 7'd3, 8'h00); send_byte(8'h83);
        tick(1);
        checks++;
        if (tx0 !== 8'hFF) begin errors++; $display("FAIL rd_tx_early got %h expected FF", tx0); end
        tick(1);
        checks++;
        if (tx0 !== 8'h59) begin errors++; $display("FAIL rd_tx_first got %h expected 59", tx0); end
        push0(1'b0, 7'd4, 8'h00); send_byte(8'h00); tick(2);
        checks++;
        if (tx0 !== 8'h5E) begin errors++; $display("FAIL rd_tx_second got %h expected 5E", tx0); end
        push0(1'b0, 7'd5, 8'h00); send_byte(8'h00); tick(2);
        checks++;
        if (tx0 !== 8'h5F) begin errors++; $display("FAIL rd_tx_third got %h expected 5F", tx0); end
        checks++;
        if (nbytes0 !== 8'd3) begin errors++; $display("FAIL rd_nbytes got %0d expected 3", nbytes0); end
        end_frame();
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL rd_drain got %0d pending expected 0", q0.size()); end
    endtask

    task automatic test_wrap();
        start_frame();
        send_byte(8'h7F); tick(2);
        push0(1'b1, 7'd127, 8'h11); send_byte(8'h11); tick(2);
        push0(1'b1, 7'd0, 8'h22);   send_byte(8'h22); tick(2);
        checks++;
        if (addr0 !== 7'd1) begin errors++; $display("FAIL wrap_addr got %0d expected 1", addr0); end
        end_frame();
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL wrap_drain got %0d pending expected 0", q0.size()); end
    endtask

    task automatic test_no_autoinc();
        logic [7:0] exp0;
        chk1 = 1'b1;
        start_frame();
        push0(1'b0, 7'd16, 8'h00); push1(1'b0, 7'd16, 8'h00);
        send_byte(8'h90); tick(2);
        checks++;
        if (tx1 !== 8'h4A) begin errors++; $display("FAIL noinc_tx_first got %h expected 4A", tx1); end
        for (int i = 1; i <= 3; i++) begin
            push0(1'b0, 7'(16 + i), 8'h00); push1(1'b0, 7'd16, 8'h00);
            send_byte(8'h00); tick(2);
        end
        exp0 = 8'(16 + 3) ^ 8'h5A;
        checks++;
        if (tx1 !== 8'h4A) begin errors++; $display("FAIL noinc_tx_last got %h expected 4A", tx1); end
        checks++;
        if (tx0 !== exp0) begin errors++; $display("FAIL inc_tx_last got %h expected %h", tx0, exp0); end
        end_frame();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL noinc_drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        chk1 = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] seq [4];
        seq = '{8'hC3, 8'hD4, 8'hE5, 8'hF6};
        start_frame();
        send_byte(8'h05); tick(2);
        push0(1'b1, 7'd5, 8'hC3); push0(1'b1, 7'd6, 8'hF6);
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1; byte_data = seq[i]; tick(1);
        end
        byte_valid = 1'b0;
        tick(2);
        checks++;
        if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_set got %b expected 1", ovr0); end
        checks++;
        if (nbytes0 !== 8'd3) begin errors++; $display("FAIL ovr_nbytes got %0d expected 3", nbytes0); end
        checks++;
        if (addr0 !== 7'd7) begin errors++; $display("FAIL ovr_addr got %0d expected 7", addr0); end
        end_frame();
        checks++;
        if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b expected 1", ovr0); end
        start_frame();
        checks++;
        if (ovr0 !== 1'b0 || nbytes0 !== 8'd0) begin
            errors++;
            $display("FAIL ovr_clear got ovr=%b nbytes=%0d expected 0/0", ovr0, nbytes0);
        end
        end_frame();
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL ovr_drain got %0d pending expected 0", q0.size()); end
    endtask

    task automatic test_frame_abort();
        start_frame();
        push0(1'b0, 7'd3, 8'h00); send_byte(8'h83); tick(2);
        checks++;
        if (tx0 !== 8'h59) begin errors++; $display("FAIL abort_tx_pre got %h expected 59", tx0); end
        push0(1'b0, 7'd4, 8'h00); send_byte(8'h00);
        frame = 1'b0;
        tick(2);
        checks++;
        if (tx0 !== 8'hFF) begin errors++; $display("FAIL abort_tx_fill got %h expected FF", tx0); end
        send_byte(8'h55); tick(3);
        checks++;
        if (nbytes0 !== 8'd2) begin errors++; $display("FAIL abort_nbytes got %0d expected 2", nbytes0); end
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL abort_drain got %0d pending expected 0", q0.size()); end
    endtask

    task automatic test_reset_midframe();
        start_frame();
        send_byte(8'h05); tick(2);
        byte_valid = 1'b1; byte_data = 8'hA1; reset = 1'b1;
        tick(1);
        byte_valid = 1'b0;
        frame = 1'b0;
        tick(1);
        checks++;
        if ({tx0, addr0, we0, re0, nbytes0, ovr0} !== {8'hFF, 7'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid got tx=%h addr=%0d we=%b re=%b nbytes=%0d ovr=%b expected FF/0/0/0/0/0",
                     tx0, addr0, we0, re0, nbytes0, ovr0);
        end
        reset = 1'b0;
        tick(3);
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL rst_drain got %0d pending expected 0", q0.size()); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_no_autoinc();
        test_overrun();
        test_frame_abort();
        test_reset_midframe();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
